ir_cmd_controller: RTL and testbench

Sequences the IR frame decoder.
- Captures each completed 32-bit frame and validates the NEC complement fields.
- Optionally filters frames by address.
- Presents the command to a consumer over a valid/ready handshake, then clears the decoder to re-arm it.
- Tracks key-hold and auto-repeat with a hold timer, pulsing key_release when the timer expires.

---
 rtl/ir_pkg.sv | 20 ++
 rtl/ir_cmd_controller_hold_timer.sv | 42 ++++
 rtl/ir_cmd_controller.sv | 143 ++++++++++++++
 tb/tb_ir_cmd_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared constants for the IR command controller: FSM encoding, NEC field offsets, timer width.
package ir_pkg;

  localparam int unsigned TIMER_W    = 23;
  localparam int unsigned STATE_W    = 3;

  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned ADDR_N_LSB = 8;
  localparam int unsigned CODE_LSB   = 16;
  localparam int unsigned CODE_N_LSB = 24;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CHECK    = 3'd1;
  localparam state_t ST_PRESENT  = 3'd2;
  localparam state_t ST_CLEAR    = 3'd3;
  localparam state_t ST_WAIT_LOW = 3'd4;

endpackage

// File: rtl/ir_cmd_controller_hold_timer.sv
// Key-hold timer: reload on accepted command, count down to zero, flag hold and pulse on expiry.
module ir_hold_timer
  import ir_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5500000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic held,
  output logic expired
);

  logic [TIMER_W-1:0] cnt;
  logic [TIMER_W-1:0] cnt_nxt;
  logic               expired_nxt;

  // A reload on the expiry cycle suppresses the release pulse.
  always_comb begin
    cnt_nxt     = cnt;
    expired_nxt = 1'b0;
    if (load) begin
      cnt_nxt = TIMER_W'(TIMEOUT_CYC);
    end else if (cnt != '0) begin
      cnt_nxt     = cnt - TIMER_W'(1);
      expired_nxt = (cnt == TIMER_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      held    <= 1'b0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      held    <= (cnt_nxt != '0);
      expired <= expired_nxt;
    end
  end

endmodule

// File: rtl/ir_cmd_controller.sv
// Sequences the IR frame decoder: capture, NEC validation, optional address filter,
// valid/ready command hand-off, decoder clear and key-hold tracking.
module ir_cmd_controller
  import ir_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC    = 5500000,
  parameter bit          ADDR_FILTER_EN = 1'b0,
  parameter logic [7:0]  ADDR_MATCH     = 8'h00,
  parameter bit          STRICT_ADDR    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_en,
  output logic        dec_en,
  input  logic        dec_ready,
  input  logic [31:0] dec_command,
  output logic        dec_clr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [7:0]  cmd_code,
  output logic        cmd_repeat,
  output logic        key_held,
  output logic        key_release,
  output logic [7:0]  err_count
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] frame_q;
  logic [31:0] frame_nxt;
  logic [7:0]  last_code;
  logic [7:0]  last_nxt;
  logic [7:0]  addr_nxt;
  logic [7:0]  code_nxt;
  logic [7:0]  err_nxt;
  logic        cmd_valid_nxt;
  logic        cmd_repeat_nxt;
  logic        dec_clr_nxt;
  logic        timer_load;
  logic        frame_ok;
  logic        addr_hit;

  assign dec_en = ctrl_en;

  assign frame_ok = (frame_q[CODE_N_LSB +: 8] == ~frame_q[CODE_LSB +: 8]) &&
                    (!STRICT_ADDR || (frame_q[ADDR_N_LSB +: 8] == ~frame_q[ADDR_LSB +: 8]));
  assign addr_hit = !ADDR_FILTER_EN || (frame_q[ADDR_LSB +: 8] == ADDR_MATCH);

  always_comb begin
    state_nxt      = state;
    frame_nxt      = frame_q;
    last_nxt       = last_code;
    addr_nxt       = cmd_addr;
    code_nxt       = cmd_code;
    err_nxt        = err_count;
    cmd_valid_nxt  = cmd_valid;
    cmd_repeat_nxt = cmd_repeat;
    dec_clr_nxt    = 1'b0;
    timer_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (dec_ready && ctrl_en) begin
          frame_nxt = dec_command;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!frame_ok) begin
          err_nxt     = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          dec_clr_nxt = 1'b1;
          state_nxt   = ST_CLEAR;
        end else if (!addr_hit) begin
          dec_clr_nxt = 1'b1;
          state_nxt   = ST_CLEAR;
        end else begin
          addr_nxt       = frame_q[ADDR_LSB +: 8];
          code_nxt       = frame_q[CODE_LSB +: 8];
          cmd_repeat_nxt = key_held && (frame_q[CODE_LSB +: 8] == last_code);
          cmd_valid_nxt  = 1'b1;
          state_nxt      = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Decoder stays un-cleared until the consumer takes the command.
        if (cmd_valid && cmd_ready) begin
          last_nxt      = cmd_code;
          timer_load    = 1'b1;
          cmd_valid_nxt = 1'b0;
          dec_clr_nxt   = 1'b1;
          state_nxt     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!dec_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_WAIT_LOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT_LOW;
      frame_q    <= '0;
      last_code  <= '0;
      cmd_addr   <= '0;
      cmd_code   <= '0;
      err_count  <= '0;
      cmd_valid  <= 1'b0;
      cmd_repeat <= 1'b0;
      dec_clr    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_q    <= frame_nxt;
      last_code  <= last_nxt;
      cmd_addr   <= addr_nxt;
      cmd_code   <= code_nxt;
      err_count  <= err_nxt;
      cmd_valid  <= cmd_valid_nxt;
      cmd_repeat <= cmd_repeat_nxt;
      dec_clr    <= dec_clr_nxt;
    end
  end

  ir_hold_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .held    (key_held),
    .expired (key_release)
  );

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Bench for ir_cmd_controller: directed scenarios plus random frames against a cycle-counting model.
module tb_ir_cmd_controller;

  localparam longint TOL = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ctrl_en, dec_ready, cmd_ready;
  logic [31:0] dec_command;
  logic        dec_en, dec_clr, cmd_valid, cmd_repeat, key_held, key_release;
  logic [7:0]  cmd_addr, cmd_code, err_count;

  logic        b_ctrl_en, b_dec_ready, b_cmd_ready;
  logic [31:0] b_dec_command;
  logic        b_dec_en, b_dec_clr, b_cmd_valid, b_cmd_repeat, b_key_held, b_key_release;
  logic [7:0]  b_cmd_addr, b_cmd_code, b_err_count;

  ir_cmd_controller #(
    .TIMEOUT_CYC(200), .ADDR_FILTER_EN(1'b0), .ADDR_MATCH(8'h00), .STRICT_ADDR(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .dec_en(dec_en), .dec_ready(dec_ready),
    .dec_command(dec_command), .dec_clr(dec_clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_code(cmd_code), .cmd_repeat(cmd_repeat), .key_held(key_held),
    .key_release(key_release), .err_count(err_count)
  );

  ir_cmd_controller #(
    .TIMEOUT_CYC(200), .ADDR_FILTER_EN(1'b1), .ADDR_MATCH(8'h04), .STRICT_ADDR(1'b0)
  ) dut_f (
    .clk(clk), .rst(rst), .ctrl_en(b_ctrl_en), .dec_en(b_dec_en), .dec_ready(b_dec_ready),
    .dec_command(b_dec_command), .dec_clr(b_dec_clr), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_addr(b_cmd_addr), .cmd_code(b_cmd_code), .cmd_repeat(b_cmd_repeat), .key_held(b_key_held),
    .key_release(b_key_release), .err_count(b_err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: edge counter, last handshake edge, last accepted code, error count.
  longint     cyc = 0;
  longint     hs_edge = 0;
  bit         have_hs = 1'b0;
  bit         hs_pending = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_err = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    have_hs    = 1'b0;
    hs_pending = 1'b0;
    m_last     = 8'h00;
    m_err      = 8'h00;
  endtask

  // One clock: advance edge count, apply a pending handshake, check hold outputs after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (hs_pending) begin
      hs_edge    = cyc;
      have_hs    = 1'b1;
      hs_pending = 1'b0;
    end
    @(negedge clk);
    check("key_held", 32'(key_held), 32'(have_hs && ((cyc - hs_edge) < TOL)));
    check("key_release", 32'(key_release), 32'(have_hs && (cyc == hs_edge + TOL)));
    check("dec_en", 32'(dec_en), 32'(ctrl_en));
  endtask

  // Offer one frame to the main DUT (assumed idle), hand it off after 'delay' stalled cycles.
  task automatic send(input logic [31:0] f, input int delay);
    bit     ok;
    bit     exp_rep;
    longint ec;
    ok = (f[31:24] == ~f[23:16]);
    dec_command = f;
    dec_ready   = 1'b1;
    tick();
    ec = cyc;
    tick();
    if (ok) begin
      exp_rep = have_hs && ((ec - hs_edge) < TOL) && (f[23:16] == m_last);
      check("cmd_valid", 32'(cmd_valid), 32'd1);
      check("cmd_addr", 32'(cmd_addr), 32'(f[7:0]));
      check("cmd_code", 32'(cmd_code), 32'(f[23:16]));
      check("cmd_repeat", 32'(cmd_repeat), 32'(exp_rep));
      check("dec_clr_hold", 32'(dec_clr), 32'd0);
      for (int i = 0; i < delay; i++) begin
        tick();
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_addr", 32'(cmd_addr), 32'(f[7:0]));
        check("stall_code", 32'(cmd_code), 32'(f[23:16]));
        check("stall_repeat", 32'(cmd_repeat), 32'(exp_rep));
        check("stall_dec_clr", 32'(dec_clr), 32'd0);
      end
      cmd_ready  = 1'b1;
      hs_pending = 1'b1;
      m_last     = f[23:16];
      tick();
      cmd_ready = 1'b0;
      check("valid_drop", 32'(cmd_valid), 32'd0);
      check("dec_clr_pulse", 32'(dec_clr), 32'd1);
    end else begin
      m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
      check("bad_no_valid", 32'(cmd_valid), 32'd0);
      check("bad_dec_clr", 32'(dec_clr), 32'd1);
    end
    check("err_count", 32'(err_count), 32'(m_err));
    dec_ready = 1'b0;
    tick();
    check("dec_clr_one_cycle", 32'(dec_clr), 32'd0);
    tick();
  endtask

  function automatic logic [31:0] rand_frame(input bit corrupt);
    logic [7:0]  c;
    logic [31:0] f;
    int          k;
    case ($urandom_range(0, 2))
      0:       c = 8'h1A;
      1:       c = 8'h2B;
      default: c = 8'($urandom);
    endcase
    f = {~c, c, 8'($urandom), 8'($urandom)};
    if (corrupt) begin
      k = 24 + int'($urandom_range(0, 7));
      f[k] = ~f[k];
    end
    return f;
  endfunction

  initial begin
    rst = 1'b1;
    ctrl_en = 1'b1; dec_ready = 1'b0; cmd_ready = 1'b0; dec_command = '0;
    b_ctrl_en = 1'b1; b_dec_ready = 1'b0; b_cmd_ready = 1'b0; b_dec_command = '0;
    model_reset();
    repeat (3) tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_addr", 32'(cmd_addr), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_repeat", 32'(cmd_repeat), 32'd0);
    check("rst_dec_clr", 32'(dec_clr), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Accepted frame, then the same key inside the hold window, then a corrupt frame.
    send(32'hE51AFF00, 0);
    repeat (95) tick();
    send(32'hE51AFF00, 0);
    send(32'hE41AFF00, 0);
    repeat (210) tick();

    // Long consumer stall.
    send(32'hBF400000, 50);

    // ctrl_en low holds off capture.
    ctrl_en = 1'b0;
    dec_command = 32'hE51AFF00;
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("en_low_valid", 32'(cmd_valid), 32'd0);
      check("en_low_clr", 32'(dec_clr), 32'd0);
    end
    dec_ready = 1'b0;
    ctrl_en = 1'b1;
    repeat (2) tick();

    // Address filter instance: matching frame accepted, other address silently dropped.
    b_dec_command = 32'hE51AFB04;
    b_dec_ready = 1'b1;
    repeat (2) tick();
    check("flt_valid", 32'(b_cmd_valid), 32'd1);
    check("flt_addr", 32'(b_cmd_addr), 32'h04);
    check("flt_code", 32'(b_cmd_code), 32'h1A);
    check("flt_repeat", 32'(b_cmd_repeat), 32'd0);
    b_cmd_ready = 1'b1;
    tick();
    b_cmd_ready = 1'b0;
    check("flt_valid_drop", 32'(b_cmd_valid), 32'd0);
    check("flt_clr", 32'(b_dec_clr), 32'd1);
    b_dec_ready = 1'b0;
    repeat (2) tick();
    b_dec_command = 32'hE51AFF00;
    b_dec_ready = 1'b1;
    repeat (2) tick();
    check("flt_drop_valid", 32'(b_cmd_valid), 32'd0);
    check("flt_drop_clr", 32'(b_dec_clr), 32'd1);
    check("flt_drop_err", 32'(b_err_count), 32'd0);
    b_dec_ready = 1'b0;
    repeat (2) tick();
    check("flt_idle_valid", 32'(b_cmd_valid), 32'd0);

    // Reset while a command is pending and the decoder still holds ready.
    dec_command = 32'hF708FF00;
    dec_ready = 1'b1;
    repeat (2) tick();
    check("pre_rst_valid", 32'(cmd_valid), 32'd1);
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_addr", 32'(cmd_addr), 32'd0);
    check("mid_rst_code", 32'(cmd_code), 32'd0);
    check("mid_rst_repeat", 32'(cmd_repeat), 32'd0);
    check("mid_rst_clr", 32'(dec_clr), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stale_valid", 32'(cmd_valid), 32'd0);
      check("stale_clr", 32'(dec_clr), 32'd0);
    end
    dec_ready = 1'b0;
    repeat (2) tick();
    send(32'hF708FF00, 1);

    // Random frames with random gaps and stalls.
    for (int n = 0; n < 40; n++) begin
      send(rand_frame($urandom_range(0, 4) == 0), int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 260)) tick();
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      send(rand_frame(1'b1), 0);
    end

    repeat (210) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
